// File: rtl/eth_frame_detector_mem_arbiter.sv
// Shares one pattern-memory BRAM port between the AXI bridge (port A, read/write) and the
// detector pattern-fetch engine (port B, read-only). B has priority; A overrides after MAX_WAIT.
module eth_frame_detector_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int RD_LATENCY = 2,
  parameter int MAX_WAIT   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  m_en,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // WAIT is entered only for RD_LATENCY >= 2, so the load value never underflows.
  localparam logic [1:0] LAT_LOAD   = (RD_LATENCY >= 2) ? 2'(RD_LATENCY - 2) : 2'd0;
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_t     state;
  logic       own_a;
  logic       own_we;
  logic [1:0] lat_cnt;
  logic [7:0] wait_cnt;

  logic elig_a;
  logic elig_b;
  logic grant_a;
  logic grant_b;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    elig_a  = a_req && !a_ack;
    elig_b  = b_req && !b_ack;
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == IDLE) begin
      if (elig_a && (!elig_b || wait_cnt >= WAIT_LIMIT)) grant_a = 1'b1;
      else if (elig_b)                                   grant_b = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      own_a    <= 1'b0;
      own_we   <= 1'b0;
      lat_cnt  <= '0;
      wait_cnt <= '0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      busy     <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;

      if (!a_req || grant_a)  wait_cnt <= '0;
      else if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;

      unique case (state)
        IDLE: begin
          if (grant_a || grant_b) begin
            own_a  <= grant_a;
            own_we <= grant_a && a_we;
            m_en   <= 1'b1;
            m_we   <= grant_a && a_we;
            m_addr <= grant_a ? a_addr : b_addr;
            if (grant_a) m_wdata <= a_wdata;
            busy   <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          m_en <= 1'b0;
          m_we <= 1'b0;
          if (own_we || RD_LATENCY == 1) begin
            state <= DONE;
          end else begin
            lat_cnt <= LAT_LOAD;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == 2'd0) state   <= DONE;
          else                 lat_cnt <= lat_cnt - 2'd1;
        end
        DONE: begin
          if (own_a) begin
            a_ack <= 1'b1;
            if (!own_we) a_rdata <= m_rdata;
          end else begin
            b_ack   <= 1'b1;
            b_rdata <= m_rdata;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
